// File: rtl/fx3_test_sequencer.sv
// fx3_test_sequencer: runs ROUNDS clear/arm/wait/sample rounds on the
// FX3 loopback core, guards each round with a timeout, tallies results.
//
// Ports:
//   clk          - system clock, rising edge
//   arst         - synchronous active-low reset
//   start        - one-cycle pulse, begins a run from IDLE or DONE
//   abort        - synchronous abort of a running test
//   core_intr    - core is in its LOAD state
//   core_stop    - core is in its COMPARE state
//   core_specreg - core result while core_stop=1 (0=pass, 1=fail)
//   core_ena     - enable to the core (high in ARM)
//   core_clr     - one-cycle clear to the core
//   busy / done  - run in progress / run finished
//   all_pass     - in DONE, no failed and no timed-out rounds
//   round_idx    - current round (0-based)
//   pass_cnt, fail_cnt, tmo_cnt - saturating result counters
//
// Build option: define STOP_ON_FAIL_EN to end a run at the first
// failed or timed-out round, leaving round_idx on that round.
module fx3_test_sequencer #(
    parameter int ROUNDS      = 16,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic             abort,
    input  logic             core_intr,
    input  logic             core_stop,
    input  logic             core_specreg,
    output logic             core_ena,
    output logic             core_clr,
    output logic             busy,
    output logic             done,
    output logic             all_pass,
    output logic [CNT_W-1:0] round_idx,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] tmo_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [TMR_W-1:0] TMR_LAST =
        TMR_W'(TIMEOUT_CYC - 1);

    localparam logic [CNT_W-1:0] IDX_LAST =
        CNT_W'(ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ARM,
        S_WAIT,
        S_SAMPLE,
        S_TMO,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [TMR_W-1:0] timer;
    logic             tmr_exp;
    logic             in_run;
    logic             kill;
    logic             go;
    logic             end_run;

    // Saturating increment: counters stick at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign tmr_exp = (timer == TMR_LAST);
    assign in_run  = (state != S_IDLE) && (state != S_DONE);
    assign kill    = abort && in_run;
    // Abort beats a coincident start.
    assign go      = start && !abort;

`ifdef STOP_ON_FAIL_EN
    logic last_bad;

    assign end_run = (round_idx == IDX_LAST) || last_bad;

    // Outcome of the round that just finished, consumed in NEXT.
    always_ff @(posedge clk) begin
        if (!arst) begin
            last_bad <= 1'b0;
        end else if (state == S_SAMPLE) begin
            last_bad <= core_specreg;
        end else if (state == S_TMO) begin
            last_bad <= 1'b1;
        end
    end
`else
    assign end_run = (round_idx == IDX_LAST);
`endif

    always_comb begin
        state_n = state;
        if (kill) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (go) state_n = S_CLEAR;
                end
                S_CLEAR: state_n = S_ARM;
                S_ARM: begin
                    if (core_intr) state_n = S_WAIT;
                    else if (tmr_exp) state_n = S_TMO;
                end
                // Stop seen on the expiry cycle still counts.
                S_WAIT: begin
                    if (core_stop) state_n = S_SAMPLE;
                    else if (tmr_exp) state_n = S_TMO;
                end
                S_SAMPLE, S_TMO: state_n = S_NEXT;
                S_NEXT: begin
                    state_n = end_run ? S_DONE : S_CLEAR;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Status and core controls are registered from the next state,
    // so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!arst) begin
            state    <= S_IDLE;
            core_ena <= 1'b0;
            core_clr <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            all_pass <= 1'b0;
        end else begin
            state    <= state_n;
            core_ena <= (state_n == S_ARM);
            core_clr <= (state_n == S_CLEAR) || kill;
            busy     <= (state_n != S_IDLE) &&
                        (state_n != S_DONE);
            done     <= (state_n == S_DONE);
            all_pass <= (state_n == S_DONE) &&
                        (fail_cnt == '0) &&
                        (tmo_cnt == '0);
        end
    end

    // Round index, timer and tallies; all hold on abort.
    always_ff @(posedge clk) begin
        if (!arst) begin
            timer     <= '0;
            round_idx <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            tmo_cnt   <= '0;
        end else if (!kill) begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        round_idx <= '0;
                        pass_cnt  <= '0;
                        fail_cnt  <= '0;
                        tmo_cnt   <= '0;
                    end
                end
                S_CLEAR: timer <= '0;
                S_ARM, S_WAIT: begin
                    if (!tmr_exp) timer <= timer + TMR_W'(1);
                end
                S_SAMPLE: begin
                    if (core_specreg)
                        fail_cnt <= sat_inc(fail_cnt);
                    else
                        pass_cnt <= sat_inc(pass_cnt);
                end
                S_TMO: tmo_cnt <= sat_inc(tmo_cnt);
                S_NEXT: begin
                    if (!end_run)
                        round_idx <= round_idx + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fx3_test_sequencer.sv
// tb_fx3_test_sequencer: random and directed runs of fx3_test_sequencer
// against a round-outcome model, with a queue-based scoreboard.
module tb_fx3_test_sequencer;

    localparam int ROUNDS = 4;
    localparam int TMO    = 16;
    localparam int CW     = 8;

    typedef struct {
        int intr_dly;  // 0 = core never enters LOAD
        int stop_dly;  // 0 = core never reaches COMPARE
        bit spec;
    } cfg_t;

    typedef struct {
        int p;
        int f;
        int t;
        int lat;
    } rexp_t;

    typedef struct {
        int idx;
        int p;
        int f;
        int t;
        int ap;
    } dexp_t;

    logic clk = 0;
    logic arst = 0;
    logic start = 0;
    logic abort = 0;
    logic core_intr = 0;
    logic core_stop = 0;
    logic core_specreg = 0;
    logic core_ena, core_clr, busy, done, all_pass;
    logic [CW-1:0] round_idx, pass_cnt, fail_cnt, tmo_cnt;

    cfg_t  cfg_q[$];
    rexp_t exp_q[$];
    dexp_t done_q[$];

    int chk = 0;
    int err = 0;
    int cyc = 0;
    int clr_cnt = 0;
    int exp_clr = 0;

    fx3_test_sequencer #(
        .ROUNDS(ROUNDS),
        .TIMEOUT_CYC(TMO),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .arst(arst),
        .start(start),
        .abort(abort),
        .core_intr(core_intr),
        .core_stop(core_stop),
        .core_specreg(core_specreg),
        .core_ena(core_ena),
        .core_clr(core_clr),
        .busy(busy),
        .done(done),
        .all_pass(all_pass),
        .round_idx(round_idx),
        .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt),
        .tmo_cnt(tmo_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input int act,
                         input int exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Core behaviour: after clr it takes the next round config,
    // raises intr intr_dly cycles into ena, then stop stop_dly later.
    initial begin : core_model
        cfg_t cur;
        int cst;
        int cnt;
        cst = 3;
        cnt = 0;
        cur = '{0, 0, 1'b0};
        forever begin
            @(negedge clk);
            if (!arst || core_clr) begin
                core_intr = 0;
                core_stop = 0;
                core_specreg = 0;
                cnt = 0;
                cst = 3;
                if (arst && cfg_q.size() > 0) begin
                    cur = cfg_q.pop_front();
                    cst = 0;
                end
            end else if (cst == 0) begin
                if (core_ena) begin
                    cnt++;
                    if (cnt == cur.intr_dly) begin
                        core_intr = 1;
                        cnt = 0;
                        cst = 1;
                    end
                end
            end else if (cst == 1) begin
                core_intr = 0;
                cnt++;
                if (cnt == cur.stop_dly) begin
                    core_stop = 1;
                    core_specreg = cur.spec;
                    cst = 2;
                end
            end
        end
    end

    // Scoreboard monitor: one entry per completed round, one per run.
    initial begin : monitor
        rexp_t re;
        dexp_t de;
        logic pe, pd;
        logic [CW-1:0] pp, pf, pt;
        int ce;
        pe = 0;
        pd = 0;
        pp = 0;
        pf = 0;
        pt = 0;
        ce = 0;
        forever begin
            @(negedge clk);
            if (core_clr === 1'b1) clr_cnt++;
            if (core_ena === 1'b1 && !pe) ce = cyc;
            if (pass_cnt > pp || fail_cnt > pf || tmo_cnt > pt) begin
                if (exp_q.size() == 0) begin
                    chk++;
                    err++;
                    $display("FAIL round_unexp: got p=%0d f=%0d t=%0d expected none",
                             pass_cnt, fail_cnt, tmo_cnt);
                end else begin
                    re = exp_q.pop_front();
                    check("round_pass", int'(pass_cnt), re.p);
                    check("round_fail", int'(fail_cnt), re.f);
                    check("round_tmo", int'(tmo_cnt), re.t);
                    check("round_lat", cyc - ce, re.lat);
                end
            end
            if (done === 1'b1 && !pd) begin
                if (done_q.size() == 0) begin
                    chk++;
                    err++;
                    $display("FAIL done_unexp: got done=1 expected 0");
                end else begin
                    de = done_q.pop_front();
                    check("done_idx", int'(round_idx), de.idx);
                    check("done_pass", int'(pass_cnt), de.p);
                    check("done_fail", int'(fail_cnt), de.f);
                    check("done_tmo", int'(tmo_cnt), de.t);
                    check("done_allpass", int'(all_pass), de.ap);
                end
            end
            pe = (core_ena === 1'b1);
            pd = (done === 1'b1);
            pp = pass_cnt;
            pf = fail_cnt;
            pt = tmo_cnt;
        end
    end

    // Round outcome from the timing rule: the round passes/fails iff
    // stop is visible by cycle TMO-1 after ARM entry, else timeout.
    task automatic prepare(input cfg_t c [ROUNDS]);
        int p, f, t, last;
        rexp_t re;
        dexp_t de;
        p = 0;
        f = 0;
        t = 0;
        last = 0;
        for (int r = 0; r < ROUNDS; r++) begin
            int s;
            if (c[r].intr_dly == 0 || c[r].stop_dly == 0)
                s = 1 << 20;
            else
                s = c[r].intr_dly - 1 + c[r].stop_dly;
            cfg_q.push_back(c[r]);
            last = r;
            if (s > TMO - 1) begin
                t++;
                re.lat = TMO + 1;
            end else begin
                if (c[r].spec) f++;
                else p++;
                re.lat = s + 2;
            end
            re.p = p;
            re.f = f;
            re.t = t;
            exp_q.push_back(re);
`ifdef STOP_ON_FAIL_EN
            if (s > TMO - 1 || c[r].spec) break;
`endif
        end
        de.idx = last;
        de.p = p;
        de.f = f;
        de.t = t;
        de.ap = (f == 0 && t == 0) ? 1 : 0;
        done_q.push_back(de);
        exp_clr = last + 1;
    endtask

    task automatic launch();
        clr_cnt = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        check("start_clr", int'(core_clr), 1);
        check("start_busy", int'(busy), 1);
        check("start_done", int'(done), 0);
        check("start_cnts",
              int'(pass_cnt | fail_cnt | tmo_cnt | round_idx), 0);
    endtask

    task automatic finish_run();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            start = 0;
            if (done === 1'b1 || n >= 3000) break;
            // Stray starts while busy must be ignored.
            if ($urandom_range(0, 9) == 0) start = 1;
            n++;
        end
        start = 0;
        check("run_bounded", int'(n < 3000), 1);
        @(negedge clk);
        check("run_done", int'(done), 1);
        check("run_busy", int'(busy), 0);
        check("run_clr_pulses", clr_cnt, exp_clr);
        check("run_rounds_left", exp_q.size(), 0);
        check("run_done_left", done_q.size(), 0);
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_ena"}, int'(core_ena), 0);
        check({nm, "_clr"}, int'(core_clr), 0);
        check({nm, "_busy"}, int'(busy), 0);
        check({nm, "_done"}, int'(done), 0);
        check({nm, "_allpass"}, int'(all_pass), 0);
        check({nm, "_idx"}, int'(round_idx), 0);
        check({nm, "_pass"}, int'(pass_cnt), 0);
        check({nm, "_fail"}, int'(fail_cnt), 0);
        check({nm, "_tmo"}, int'(tmo_cnt), 0);
    endtask

    task automatic base(output cfg_t c [ROUNDS]);
        for (int r = 0; r < ROUNDS; r++) c[r] = '{2, 3, 1'b0};
    endtask

    initial begin : stim
        cfg_t c [ROUNDS];
        int n;

        arst = 0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        arst = 1;
        @(negedge clk);

        // All rounds pass.
        base(c);
        prepare(c);
        launch();
        finish_run();

        // Round 2 fails.
        base(c);
        c[2].spec = 1;
        prepare(c);
        launch();
        finish_run();

        // Round 1 never stops: timeout.
        base(c);
        c[1].stop_dly = 0;
        prepare(c);
        launch();
        finish_run();

        // Stop on the last timer cycle, then one cycle too late,
        // then a core that never enters LOAD.
        base(c);
        c[0].stop_dly = 14;
        c[1].stop_dly = 15;
        c[3].intr_dly = 0;
        prepare(c);
        launch();
        finish_run();

        // Abort while waiting for stop in round 1.
        base(c);
        c[1].stop_dly = 10;
        prepare(c);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        done_q.delete();
        launch();
        n = 0;
        while (pass_cnt !== 8'd1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (core_ena !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (core_ena !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach", int'(n < 200), 1);
        cfg_q.delete();
        clr_cnt = 0;
        abort = 1;
        start = 1;
        @(negedge clk);
        abort = 0;
        start = 0;
        check("abort_ena", int'(core_ena), 0);
        check("abort_clr", int'(core_clr), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_idx", int'(round_idx), 1);
        check("abort_pass", int'(pass_cnt), 1);
        repeat (4) @(negedge clk);
        check("abort_clr_off", int'(core_clr), 0);
        check("abort_idle", int'(busy), 0);
        check("abort_clr_pulses", clr_cnt, 1);
        check("abort_hold", int'(pass_cnt), 1);
        check("abort_rounds_left", exp_q.size(), 0);

        // Random rounds.
        repeat (15) begin
            for (int r = 0; r < ROUNDS; r++) begin
                c[r].intr_dly = ($urandom_range(0, 9) == 0) ? 0 :
                                int'($urandom_range(1, 4));
                c[r].stop_dly = ($urandom_range(0, 9) == 0) ? 0 :
                                int'($urandom_range(1, 17));
                c[r].spec = 1'($urandom_range(0, 1));
            end
            prepare(c);
            launch();
            finish_run();
        end

        // Reset pulse while armed, restart right after release.
        base(c);
        cfg_q.delete();
        launch();
        n = 0;
        while (core_ena !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_arm", int'(n < 50), 1);
        arst = 0;
        @(negedge clk);
        check_zero("midrst");
        prepare(c);
        arst = 1;
        launch();
        finish_run();

        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

endmodule
